// File: rtl/frame_transmitter.sv
// -----------------------------------------------------------------------------
// frame_transmitter
//
// Serialises a frame of NCHARS 6-bit-style character codes (one per byte of
// i_data, most significant byte first) into printable ASCII bytes for a UART
// transmitter. Each byte is handed over with a one-cycle strobe, then the
// block waits for the UART to go idle before moving to the next character.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous, active-high reset
//   i_data     : frame of codes; code 0 is i_data[8*NCHARS-1 -: 8]
//   i_send     : frame request, only looked at while o_ready=1
//   i_tx_busy  : UART transmitter busy
//   o_tx_data  : registered ASCII byte to the UART, held between strobes
//   o_tx_stb   : registered one-cycle byte strobe
//   o_ready    : high only while idle
//   o_done     : one-cycle pulse when the last byte has been accepted
//   o_err      : sticky, set when the frame contained an unmapped code;
//                cleared by the next accepted request or by reset
// -----------------------------------------------------------------------------
module frame_transmitter #(
    parameter int NCHARS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [8*NCHARS-1:0]   i_data,
    input  logic                  i_send,
    input  logic                  i_tx_busy,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_stb,
    output logic                  o_ready,
    output logic                  o_done,
    output logic                  o_err
);

    localparam int         W    = 8 * NCHARS;
    localparam logic [3:0] LAST = 4'(NCHARS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_WAIT
    } state_t;

    state_t       state_q,   state_d;
    logic [3:0]   cnt_q,     cnt_d;
    logic [W-1:0] shreg_q,   shreg_d;
    logic [7:0]   tx_data_q, tx_data_d;
    logic         tx_stb_q,  tx_stb_d;
    logic         done_q,    done_d;
    logic         err_q,     err_d;

    // Code-to-ASCII translation of the byte currently at the head of the
    // shift register. Anything outside 0x00-0x3F goes out as '?' and is
    // flagged so the frame can be marked as bad.
    logic [7:0] top_code;
    logic [7:0] top_ascii;
    logic       top_bad;

    assign top_code = shreg_q[W-1 -: 8];

    always_comb begin
        top_ascii = 8'h3F;
        top_bad   = 1'b0;
        if (top_code <= 8'h09) begin
            top_ascii = top_code + 8'h30;          // '0'..'9'
        end else if (top_code <= 8'h23) begin
            top_ascii = top_code + 8'h37;          // 'A'..'Z'
        end else if (top_code <= 8'h3D) begin
            top_ascii = top_code + 8'h3D;          // 'a'..'z'
        end else if (top_code == 8'h3E) begin
            top_ascii = 8'h3F;                     // '?'
        end else if (top_code == 8'h3F) begin
            top_ascii = 8'h21;                     // '!'
        end else begin
            top_bad   = 1'b1;
        end
    end

    // Next-state and output logic. The strobe and done pulse default to 0
    // so they can only ever last the single cycle after the edge that set
    // them; the data byte defaults to holding its value.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        tx_data_d = tx_data_q;
        tx_stb_d  = 1'b0;
        done_d    = 1'b0;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                if (i_send) begin
                    shreg_d = i_data;
                    cnt_d   = 4'd0;
                    err_d   = 1'b0;
                    state_d = S_SEND;
                end
            end

            S_SEND: begin
                if (!i_tx_busy) begin
                    tx_stb_d  = 1'b1;
                    tx_data_d = top_ascii;
                    if (top_bad) begin
                        err_d = 1'b1;
                    end
                    state_d = S_GAP;
                end
            end

            // One dead cycle after the strobe: the UART needs an edge to
            // raise its busy flag, so busy is not trusted here.
            S_GAP: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (!i_tx_busy) begin
                    if (cnt_q == LAST) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        shreg_d = shreg_q << 8;
                        cnt_d   = cnt_q + 4'd1;
                        state_d = S_SEND;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            shreg_q   <= '0;
            tx_data_q <= 8'h00;
            tx_stb_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            tx_data_q <= tx_data_d;
            tx_stb_q  <= tx_stb_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign o_tx_data = tx_data_q;
    assign o_tx_stb  = tx_stb_q;
    assign o_done    = done_q;
    assign o_err     = err_q;
    assign o_ready   = (state_q == S_IDLE);

endmodule

// File: tb/tb_frame_transmitter.sv
// -----------------------------------------------------------------------------
// tb_frame_transmitter
//
// Directed and randomised frames against a table-driven model of the
// code-to-ASCII alphabet. A monitor logs every strobe (byte, cycle, error
// flag) just after each rising edge; a UART stand-in raises busy for a
// programmable number of cycles after each strobe or holds it high.
// -----------------------------------------------------------------------------
module tb_frame_transmitter;

    localparam int N = 10;
    localparam int W = 8 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_send;
    logic         i_tx_busy;
    logic [W-1:0] i_data;
    logic [7:0]   o_tx_data;
    logic         o_tx_stb;
    logic         o_ready;
    logic         o_done;
    logic         o_err;

    frame_transmitter #(.NCHARS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_data    (i_data),
        .i_send    (i_send),
        .i_tx_busy (i_tx_busy),
        .o_tx_data (o_tx_data),
        .o_tx_stb  (o_tx_stb),
        .o_ready   (o_ready),
        .o_done    (o_done),
        .o_err     (o_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // monitor state
    int         cyc = 0;
    int         t_send = 0;
    logic [7:0] rx_q[$];
    int         stb_cyc[$];
    logic       err_q[$];
    int         n_done = 0;
    int         done_cyc = -1;
    logic       done_ready = 1'b0;
    int         stab_err = 0;
    logic [7:0] last_data = 8'h00;
    logic       have_last = 1'b0;
    logic       prev_stb = 1'b0;

    // UART stand-in
    int   busy_len = 0;
    logic busy_hold = 1'b0;
    int   bcnt = 0;

    // ---------------- model ----------------
    function automatic logic [7:0] ref_ascii(input logic [7:0] c);
        string tbl;
        tbl = "0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz?!";
        if (c < 8'd64) return tbl[int'(c)];
        return 8'h3F;
    endfunction

    function automatic logic [7:0] code_of(input logic [W-1:0] d, input int k);
        return d[W-1-8*k -: 8];
    endfunction

    function automatic logic [W-1:0] rand_frame(input bit allow_bad);
        logic [W-1:0] d;
        logic [7:0]   c;
        d = '0;
        for (int k = 0; k < N; k++) begin
            c = 8'($urandom_range(0, 63));
            if (allow_bad && $urandom_range(0, 7) == 0) c = 8'($urandom_range(64, 255));
            d[W-1-8*k -: 8] = c;
        end
        return d;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        rx_q.delete();
        stb_cyc.delete();
        err_q.delete();
        n_done     = 0;
        done_cyc   = -1;
        done_ready = 1'b0;
        stab_err   = 0;
    endtask

    // Compare the logged frame against the model: byte values, the error
    // flag as it stood at each strobe, one done pulse with ready, stability.
    task automatic verify(input string tag, input logic [W-1:0] d);
        logic e;
        e = 1'b0;
        check($sformatf("%s nstb", tag), 32'(rx_q.size()), N);
        for (int k = 0; k < N; k++) begin
            if (code_of(d, k) >= 8'h40) e = 1'b1;
            check($sformatf("%s byte%0d", tag, k),
                  (k < rx_q.size()) ? 32'(rx_q[k]) : 32'hDEAD, 32'(ref_ascii(code_of(d, k))));
            check($sformatf("%s err_at%0d", tag, k),
                  (k < err_q.size()) ? 32'(err_q[k]) : 32'hDEAD, 32'(e));
        end
        check($sformatf("%s ndone", tag), 32'(n_done), 1);
        check($sformatf("%s ready_at_done", tag), 32'(done_ready), 1);
        check($sformatf("%s stable", tag), 32'(stab_err), 0);
        check($sformatf("%s err_end", tag), 32'(o_err), 32'(e));
    endtask

    task automatic start_frame(input string tag, input logic [W-1:0] d);
        @(negedge clk);
        check($sformatf("%s ready_before", tag), 32'(o_ready), 1);
        i_data = d;
        i_send = 1'b1;
        t_send = cyc;
        @(negedge clk);
        i_send = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n;
        n = 0;
        while (o_done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("%s done_seen", tag), 32'(o_done), 1);
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst) begin
                have_last = 1'b0;
                prev_stb  = 1'b0;
            end else begin
                if (o_tx_stb) begin
                    if (prev_stb) stab_err++;
                    rx_q.push_back(o_tx_data);
                    stb_cyc.push_back(cyc);
                    err_q.push_back(o_err);
                    last_data = o_tx_data;
                    have_last = 1'b1;
                end else if (have_last && o_tx_data !== last_data) begin
                    stab_err++;
                end
                if (o_done) begin
                    n_done++;
                    done_cyc   = cyc;
                    done_ready = o_ready;
                end
                prev_stb = o_tx_stb;
            end
        end
    end

    // ---------------- UART stand-in ----------------
    initial begin
        i_tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (o_tx_stb) bcnt = busy_len;
            else if (bcnt > 0) bcnt--;
            i_tx_busy = busy_hold || (bcnt > 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [W-1:0] d;
        logic [W-1:0] d2;
        logic [W-1:0] lit;
        int           t_rel;
        int           n;

        // reset with a simultaneous request: reset must win
        rst    = 1'b1;
        i_send = 1'b1;
        i_data = rand_frame(1'b0);
        repeat (3) @(negedge clk);
        check("rst ready", 32'(o_ready), 1);
        check("rst stb",   32'(o_tx_stb), 0);
        check("rst done",  32'(o_done), 0);
        check("rst err",   32'(o_err), 0);
        check("rst data",  32'(o_tx_data), 0);
        rst    = 1'b0;
        i_send = 1'b0;
        @(negedge clk);
        check("post_rst ready", 32'(o_ready), 1);

        // greeting frame, busy 4 cycles after each strobe
        clear_log();
        busy_len = 4;
        d   = 80'h11282F2F320102030405;
        lit = 80'h48656C6C6F3132333435;
        start_frame("hello", d);
        wait_done("hello", 1000);
        verify("hello", d);
        for (int k = 0; k < N; k++)
            check($sformatf("hello lit%0d", k),
                  (k < rx_q.size()) ? 32'(rx_q[k]) : 32'hDEAD, 32'(lit[W-1-8*k -: 8]));

        // alphabet boundaries and unmapped codes
        clear_log();
        busy_len = 1;
        d   = 80'h3E3F00090A23243D40FF;
        lit = 80'h3F213039415A617A3F3F;
        start_frame("bounds", d);
        wait_done("bounds", 1000);
        verify("bounds", d);
        for (int k = 0; k < N; k++)
            check($sformatf("bounds lit%0d", k),
                  (k < rx_q.size()) ? 32'(rx_q[k]) : 32'hDEAD, 32'(lit[W-1-8*k -: 8]));

        // busy tied low: strobe and done timing
        clear_log();
        busy_len = 0;
        d = rand_frame(1'b1);
        start_frame("timing", d);
        wait_done("timing", 1000);
        verify("timing", d);
        for (int k = 0; k < N; k++)
            check($sformatf("timing stb_cyc%0d", k),
                  (k < stb_cyc.size()) ? 32'(stb_cyc[k] - t_send) : 32'hDEAD, 32'(2 + 3 * k));
        check("timing done_cyc", 32'(done_cyc - t_send), 32'(3 * N + 1));

        // busy held high for 50 cycles while the first byte is pending
        clear_log();
        busy_len  = 0;
        busy_hold = 1'b1;
        d = rand_frame(1'b0);
        start_frame("stall", d);
        repeat (50) @(negedge clk);
        check("stall no_stb", 32'(rx_q.size()), 0);
        check("stall not_ready", 32'(o_ready), 0);
        t_rel     = cyc;
        busy_hold = 1'b0;
        wait_done("stall", 1000);
        check("stall first_stb", (stb_cyc.size() > 0) ? 32'(stb_cyc[0] - t_rel) : 32'hDEAD, 1);
        verify("stall", d);

        // request re-pulsed mid-frame is ignored; request in the done cycle
        // starts the next frame and clears the error flag
        clear_log();
        busy_len = 2;
        d = rand_frame(1'b0);
        d[7:0] = 8'hC5;
        d2 = rand_frame(1'b0);
        start_frame("repulse", d);
        repeat (8) @(negedge clk);
        i_data = d2;
        i_send = 1'b1;
        repeat (3) @(negedge clk);
        i_send = 1'b0;
        wait_done("repulse", 1000);
        verify("repulse", d);
        clear_log();
        i_data = d2;
        i_send = 1'b1;
        t_send = cyc;
        @(negedge clk);
        i_send = 1'b0;
        check("b2b err_cleared", 32'(o_err), 0);
        check("b2b busy", 32'(o_ready), 0);
        wait_done("b2b", 1000);
        verify("b2b", d2);

        // reset after the 4th strobe abandons the frame
        clear_log();
        busy_len = 0;
        d = rand_frame(1'b1);
        start_frame("abort", d);
        n = 0;
        while (rx_q.size() < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort reached4", 32'(rx_q.size()), 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort ready", 32'(o_ready), 1);
        check("abort stb",   32'(o_tx_stb), 0);
        check("abort data",  32'(o_tx_data), 0);
        check("abort err",   32'(o_err), 0);
        repeat (60) @(negedge clk);
        check("abort nstb",  32'(rx_q.size()), 4);
        check("abort ndone", 32'(n_done), 0);
        check("abort idle",  32'(o_ready), 1);

        // randomised frames with random UART busy lengths
        for (int f = 0; f < 8; f++) begin
            clear_log();
            busy_len = $urandom_range(0, 5);
            d = rand_frame(1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            start_frame($sformatf("rnd%0d", f), d);
            wait_done($sformatf("rnd%0d", f), 1000);
            verify($sformatf("rnd%0d", f), d);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frame_transmitter.md
FRAME_TRANSMITTER -- requirements
Module: frame_transmitter

Interface
REQ-001 The block SHALL have parameter NCHARS, default 10, giving the number of 8-bit character codes per frame (range 1-15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port i_data, input, 8*NCHARS bits: frame of codes; code 0 is i_data[8*NCHARS-1 -: 8], sent first.
REQ-005 The block SHALL have port i_send, input, 1 bit: frame request; sampled only while o_ready=1.
REQ-006 The block SHALL have port i_tx_busy, input, 1 bit: UART transmitter busy.
REQ-007 The block SHALL have port o_tx_data, output, 8 bits: ASCII byte to the UART, registered.
REQ-008 The block SHALL have port o_tx_stb, output, 1 bit: one-cycle byte strobe to the UART, registered.
REQ-009 The block SHALL have port o_ready, output, 1 bit: high only in IDLE.
REQ-010 The block SHALL have port o_done, output, 1 bit: one-cycle pulse on frame completion.
REQ-011 The block SHALL have port o_err, output, 1 bit: sticky flag set when the current or last frame contained an unmapped code.

Function
REQ-012 The block SHALL use states IDLE, SEND, GAP and WAIT, plus a character counter 0..NCHARS-1 and a shift register of width 8*NCHARS.
REQ-013 In IDLE with i_send=1, the block SHALL capture i_data into the shift register, clear the counter and o_err, and enter SEND; i_send in any other state SHALL be ignored.
REQ-014 In SEND with i_tx_busy=0, the block SHALL register o_tx_stb=1, register o_tx_data as the mapping of the shift register's top byte, and enter GAP; with i_tx_busy=1 it SHALL remain in SEND.
REQ-015 GAP SHALL last exactly one cycle, drive o_tx_stb to 0, ignore i_tx_busy, and enter WAIT.
REQ-016 In WAIT with i_tx_busy=0, if the counter is below NCHARS-1, the block SHALL shift left 8 bits, increment the counter, and enter SEND.
REQ-017 In WAIT with i_tx_busy=0 and the counter equal to NCHARS-1, the block SHALL enter IDLE with o_done=1 for one cycle and o_ready=1 in that same cycle.
REQ-018 o_tx_stb SHALL be high for exactly one cycle per character and exactly NCHARS times per frame.
REQ-019 o_tx_data SHALL hold stable from its strobe until the next strobe.
REQ-020 Latency: with i_tx_busy held low, the first strobe SHALL occur 2 cycles after the edge that samples i_send, and successive strobes SHALL be 3 cycles apart.
REQ-021 Code mapping:
- 0x00-0x09 -> 0x30-0x39
- 0x0A-0x23 -> 0x41-0x5A
- 0x24-0x3D -> 0x61-0x7A
- 0x3E -> 0x3F
- 0x3F -> 0x21
REQ-022 Codes 0x40-0xFF SHALL be sent as 0x3F and SHALL set o_err, which holds until the next accepted i_send or reset.
REQ-023 Busy asserted in WAIT SHALL stall indefinitely without strobing; no timeout applies.
REQ-024 i_send asserted in the o_done cycle SHALL be accepted, since o_ready=1 in that cycle.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, counter 0, shift register 0, o_tx_data=0x00, o_tx_stb=0, o_done=0, o_err=0, o_ready=1.
REQ-026 Reset mid-frame SHALL abandon the frame with no further strobes and no o_done.
REQ-027 rst SHALL take priority over i_send in the same cycle.

Verification
REQ-028 Scenario: NCHARS=10, i_data codes 11 28 2F 2F 32 01 02 03 04 05, i_tx_busy modelled as 4 cycles high after each strobe -> bytes 48 65 6C 6C 6F 31 32 33 34 35 in order, 10 strobes, one o_done, o_err=0.
REQ-029 Scenario: codes 3E 3F 00 09 0A 23 24 3D 40 FF -> bytes 3F 21 30 39 41 5A 61 7A 3F 3F, with o_err=1 after the 9th byte.
REQ-030 Scenario: i_tx_busy held high 50 cycles while in SEND -> no strobe until busy falls, then a strobe 1 cycle later.
REQ-031 Scenario: i_send re-pulsed during a frame -> ignored, exactly 10 strobes; i_send in the o_done cycle -> second frame starts and o_err is cleared.
REQ-032 Scenario: rst pulsed after the 4th strobe -> no further strobes, o_done never pulses, o_ready=1 the cycle after the reset edge.
REQ-033 Scenario: i_tx_busy tied low -> strobes on cycles 2, 5, 8, ... 29 after i_send, o_done on cycle 31.
